// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide unit with a fixed-latency busy counter.
// Ports: clk, reset (async, active-high); start/op/a/b issue an operation;
// busy = operation in flight, pending = busy | start; hi/lo = HI/LO registers.
// Optional macro MULDIV_DIV_EN: when defined, DIV/DIVU are implemented;
// when undefined, no divider exists and op 2/3 behave as reserved no-ops.

module muldiv_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        pending,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        res_we;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Sign-extending to 64 bits makes the low 64 bits of the product
    // the signed result without relying on signed-context rules.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'b0, a_q} * {32'b0, b_q};
    end

`ifdef MULDIV_DIV_EN
    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic        div_zero, div_ovf;

    always_comb begin
        div_zero = (b_q == 32'd0);
        div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        quo_s    = $signed(a_q) / $signed(b_q);
        rem_s    = $signed(a_q) % $signed(b_q);
        quo_u    = a_q / b_q;
        rem_u    = a_q % b_q;
    end
`endif

    // Result selected from the operands latched at the start edge.
    always_comb begin
        res_we = 1'b1;
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        case (op_q)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
`ifdef MULDIV_DIV_EN
            OP_DIV: begin
                if (div_zero) begin
                    res_we = 1'b0;
                end else if (div_ovf) begin
                    // INT_MIN / -1 wraps back to INT_MIN, remainder 0
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            OP_DIVU: begin
                res_we = !div_zero;
                res_hi = rem_u;
                res_lo = quo_u;
            end
`endif
            default: res_we = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            a_d     = a;
                            b_d     = b;
                            op_d    = op;
                            cnt_d   = 4'(MUL_CYCLES);
                            state_d = S_RUN;
                        end
`ifdef MULDIV_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            a_d     = a;
                            b_d     = b;
                            op_d    = op;
                            cnt_d   = 4'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
`endif
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    if (res_we) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy    = (cnt_q != 4'd0);
    assign pending = busy | start;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: vector table plus scoreboard bench for muldiv_ctrl.
// Expectations follow the MULDIV_DIV_EN setting of the build.

module tb_muldiv_ctrl;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif
    localparam int MULN = 5;
    localparam int DIVN = DIV_ON ? 10 : 0;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy;
    logic        pending;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .pending (pending),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        bit          keep;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    vec_t        tbl[$];
    res_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic void add(input string nm, input logic [2:0] o,
                                input logic [31:0] x, input logic [31:0] y,
                                input int n, input bit keep,
                                input logic [31:0] eh, input logic [31:0] el);
        vec_t v;
        v.name = nm; v.op = o; v.a = x; v.b = y;
        v.n = n; v.keep = keep; v.hi = eh; v.lo = el;
        tbl.push_back(v);
    endfunction

    // Issue one op from IDLE, count busy cycles, then score hi/lo.
    task automatic run_op(input vec_t v);
        res_t r;
        int   k;
        @(negedge clk);
        chk({v.name, " idle"}, {31'b0, busy}, 32'd0);
        start = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        #1;
        chk({v.name, " pending"}, {31'b0, pending}, 32'd1);
        r.hi = v.keep ? m_hi : v.hi;
        r.lo = v.keep ? m_lo : v.lo;
        sb.push_back(r);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        k     = 0;
        while (busy === 1'b1 && k < 20) begin
            chk({v.name, " hold hi"}, hi, m_hi);
            chk({v.name, " hold lo"}, lo, m_lo);
            @(posedge clk);
            #1;
            k++;
        end
        chk({v.name, " cycles"}, 32'(k), 32'(v.n));
        r = sb.pop_front();
        chk({v.name, " hi"}, hi, r.hi);
        chk({v.name, " lo"}, lo, r.lo);
        m_hi = r.hi;
        m_lo = r.lo;
    endtask

    task automatic simple(input string nm, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input int n, input logic [31:0] eh,
                          input logic [31:0] el);
        vec_t v;
        v.name = nm; v.op = o; v.a = x; v.b = y;
        v.n = n; v.keep = 1'b0; v.hi = eh; v.lo = el;
        run_op(v);
    endtask

    initial begin
        int k;

        add("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, MULN, 1'b0,
            32'hFFFF_FFFF, 32'hFFFF_FFEB);
        add("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULN, 1'b0,
            32'hFFFF_FFFE, 32'h0000_0001);
        add("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, MULN, 1'b0,
            32'h4000_0000, 32'h0000_0000);
        add("multu_sh", 3'd1, 32'h1234_5678, 32'h10, MULN, 1'b0,
            32'h0000_0001, 32'h2345_6780);
        add("mthi", 3'd4, 32'hDEAD_BEEF, 32'd0, 0, 1'b0,
            32'hDEAD_BEEF, 32'h2345_6780);
        add("mtlo", 3'd5, 32'h0000_1234, 32'd0, 0, 1'b0,
            32'hDEAD_BEEF, 32'h0000_1234);
        add("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, DIVN, !DIV_ON,
            32'hFFFF_FFFF, 32'hFFFF_FFFD);
        add("divu", 3'd3, 32'd100, 32'd7, DIVN, !DIV_ON,
            32'd2, 32'd14);
        add("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIVN, !DIV_ON,
            32'd0, 32'h8000_0000);
        add("div_negb", 3'd2, 32'd7, 32'hFFFF_FFFE, DIVN, !DIV_ON,
            32'd1, 32'hFFFF_FFFD);
        add("divu_zero", 3'd3, 32'd55, 32'd0, DIVN, 1'b1, 32'd0, 32'd0);
        add("div_zero", 3'd2, 32'd5, 32'd0, DIVN, 1'b1, 32'd0, 32'd0);
        add("rsv6", 3'd6, 32'hAAAA_AAAA, 32'd3, 0, 1'b1, 32'd0, 32'd0);
        add("rsv7", 3'd7, 32'h5555_5555, 32'd3, 0, 1'b1, 32'd0, 32'd0);

        #1 reset = 1'b1;
        #2;
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst pending", {31'b0, pending}, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) run_op(tbl[i]);

        // Start and operand changes while running must be ignored.
        simple("pre", 3'd5, 32'd0, 32'd0, 0, m_hi, 32'd0);
        simple("pre2", 3'd4, 32'd0, 32'd0, 0, 32'd0, 32'd0);
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 20) begin
            if (k == 2) begin
                @(negedge clk);
                start = 1'b1; op = 3'd5; a = 32'h1234; b = 32'h99;
                #1;
                chk("run pending", {31'b0, pending}, 32'd1);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            k++;
        end
        chk("run cycles", 32'(k), 32'(MULN));
        chk("run hi", hi, 32'd0);
        chk("run lo", lo, 32'd6);
        m_hi = 32'd0;
        m_lo = 32'd6;
        simple("mtlo_idle", 3'd5, 32'h1234, 32'd0, 0, 32'd0, 32'h1234);

        // Reset mid-operation aborts without any later write.
        simple("mthi_a", 3'd4, 32'hAAAA, 32'd0, 0, 32'hAAAA, 32'h1234);
        simple("mtlo_a", 3'd5, 32'h5555, 32'd0, 0, 32'hAAAA, 32'h5555);
        @(negedge clk);
        start = 1'b1;
        op = DIV_ON ? 3'd2 : 3'd0;
        a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort busy pre", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (15) @(posedge clk);
        #1;
        chk("post busy", {31'b0, busy}, 32'd0);
        chk("post hi", hi, 32'd0);
        chk("post lo", lo, 32'd0);
        simple("first_after", 3'd1, 32'd3, 32'd4, MULN, 32'd0, 32'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, busy cycles for MULT/MULTU (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage issue strobe for one mul/div/move-to operation.
REQ-006 SHALL have port op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-007 SHALL have port a  input  32  rs operand.
REQ-008 SHALL have port b  input  32  rt operand.
REQ-009 SHALL have port busy  output  1  a multi-cycle operation is in progress.
REQ-010 SHALL have port pending  output  1  busy OR start, for the D-stage hazard unit.
REQ-011 SHALL have port hi  output  32  HI register contents.
REQ-012 SHALL have port lo  output  32  LO register contents.

Function
REQ-013 SHALL use two states: IDLE (count 0) and RUN (count nonzero), with a 4-bit down-counter; busy = (count != 0).
REQ-014 SHALL accept start only in IDLE; in RUN, start and all inputs are ignored, with no state change.
REQ-015 On an accepted MULT/MULTU/DIV/DIVU, SHALL latch a, b and op at that edge and load the counter with MUL_CYCLES or DIV_CYCLES.
REQ-016 SHALL decrement the counter on each edge in RUN.
REQ-017 On the edge where the counter goes 1->0, SHALL write hi/lo; busy SHALL fall on that same edge.
REQ-018 Result SHALL be visible exactly N cycles after the start edge (N = MUL_CYCLES or DIV_CYCLES), and busy SHALL be high for exactly N cycles.
REQ-019 MULT SHALL write {hi,lo} = signed 64-bit a*b; MULTU SHALL write the unsigned 64-bit product.
REQ-020 DIV SHALL write lo = signed quotient truncated toward zero and hi = remainder, with the sign of the dividend.
REQ-021 DIVU SHALL write the unsigned quotient to lo and the unsigned remainder to hi.
REQ-022 DIV with a=32'h80000000, b=32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-023 For DIV/DIVU with b==0, SHALL still run the full busy period and leave hi/lo unchanged.
REQ-024 MTHI/MTLO accepted in IDLE SHALL write a into hi or lo at that edge, with no busy period.
REQ-025 Reserved op codes SHALL be a no-op: no busy, no register write.
REQ-026 hi/lo SHALL change only per REQ-017, REQ-024 or reset.

Reset
REQ-027 reset SHALL immediately force counter=0, busy=0, hi=0, lo=0 and clear latched operands, independent of clk.
REQ-028 reset asserted mid-operation SHALL abort it with no hi/lo write.
REQ-029 After reset deasserts, the first accepted start SHALL behave per REQ-015; pending SHALL equal start while in IDLE.

Configuration
REQ-030 Macro MULDIV_DIV_EN defined: DIV/DIVU SHALL be implemented per REQ-020..REQ-023.
REQ-031 Macro MULDIV_DIV_EN undefined: no divider logic SHALL be present, and op 2/3 SHALL be treated as reserved per REQ-025.

Verification
REQ-032 Reset, then MULT with a=-3, b=7 -> busy high 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-033 MULTU with a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 after 5 cycles.
REQ-034 DIV with a=-7, b=2 -> after 10 cycles lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU with b=0 -> hi/lo unchanged after 10 busy cycles.
REQ-035 MTLO a=32'h1234 during RUN -> ignored; MTLO a=32'h1234 in IDLE -> lo=32'h1234 next cycle, busy stays 0.
REQ-036 Start DIV, assert reset at cycle 4 -> busy=0, hi=lo=0 immediately; no later write occurs.
REQ-037 Build without MULDIV_DIV_EN, issue DIV -> busy stays 0, hi/lo unchanged.
